player_logic_grid: RTL

//  Parametrised player controller: grid movement, directional sword attack, post-action cooldown
//  and a sprite animation counter. Adds respawn and freeze hooks for the Game State Controller.

---
 rtl/player_logic_grid.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/player_logic_grid.sv
// -----------------------------------------------------------------------------
// player_logic_grid
//   Grid-based player controller. It handles tile movement, a directional
//   sword attack, a cooldown after each action and a sprite animation counter.
//   It also has respawn and freeze hooks for the game state controller.
//   All game-time behaviour advances only on a frame tick (trigger=1 while
//   freeze=0). The press/release input buffer is updated on every clock.
//
// Ports
//   clk                in   system clock
//   reset              in   synchronous reset, active low
//   trigger            in   frame tick, one-cycle pulse
//   btn_press[4:0]     in   press pulses   {attack,right,left,down,up}
//   btn_release[4:0]   in   release pulses, same bit order
//   respawn            in   move to the spawn tile and abort the current action
//   freeze             in   1 = ignore trigger (FSM and counters hold)
//   player_x/y         out  player tile
//   player_direction   out  00 up, 01 right, 10 down, 11 left
//   player_orientation out  last horizontal facing (01 right, 11 left)
//   player_sprite      out  animation frame index (3 or 2)
//   sword_x/y          out  sword tile, 0 when the sword is not visible
//   sword_visible      out  sword is drawn and collidable
//   sword_orientation  out  direction code of the sword
//   busy               out  FSM is not idle
// -----------------------------------------------------------------------------
module player_logic_grid #(
    parameter int XW             = 4,
    parameter int YW             = 4,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 15,
    parameter int Y_MIN          = 1,
    parameter int Y_MAX          = 11,
    parameter int SPAWN_X        = 1,
    parameter int SPAWN_Y        = 3,
    parameter int ATTACK_TICKS   = 4,
    parameter int COOLDOWN_TICKS = 2,
    parameter int ANIM_PERIOD    = 21,
    parameter int ANIM_SPLIT     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trigger,
    input  logic [4:0]    btn_press,
    input  logic [4:0]    btn_release,
    input  logic          respawn,
    input  logic          freeze,
    output logic [XW-1:0] player_x,
    output logic [YW-1:0] player_y,
    output logic [1:0]    player_direction,
    output logic [1:0]    player_orientation,
    output logic [3:0]    player_sprite,
    output logic [XW-1:0] sword_x,
    output logic [YW-1:0] sword_y,
    output logic          sword_visible,
    output logic [1:0]    sword_orientation,
    output logic          busy
);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [XW-1:0] X_LO  = XW'(X_MIN);
    localparam logic [XW-1:0] X_HI  = XW'(X_MAX);
    localparam logic [YW-1:0] Y_LO  = YW'(Y_MIN);
    localparam logic [YW-1:0] Y_HI  = YW'(Y_MAX);
    localparam logic [XW-1:0] X_SPN = XW'(SPAWN_X);
    localparam logic [YW-1:0] Y_SPN = YW'(SPAWN_Y);

    // One shared counter serves both ATTACK and COOLDOWN.
    localparam int CNT_MAX = (ATTACK_TICKS > COOLDOWN_TICKS) ? ATTACK_TICKS : COOLDOWN_TICKS;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] ATK_LAST  = CNT_W'(ATTACK_TICKS);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);

    localparam int AW = (ANIM_PERIOD > 2) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_PERIOD - 1);
    localparam logic [AW-1:0] ANIM_SPL  = AW'(ANIM_SPLIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_ATTACK,
        ST_COOLDOWN
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [AW-1:0]    anim_cnt;
    logic [4:0]       cmd_buf;
    logic             armed;

    logic             step;
    logic             move_now, atk_entry, atk_exit;
    logic             has_dir;
    logic [1:0]       move_dir, atk_dir, sel_dir;
    logic [XW-1:0]    tgt_x;
    logic [YW-1:0]    tgt_y;
    logic             tgt_ok;

    assign step    = trigger & ~freeze;
    assign has_dir = |cmd_buf[3:0];
    assign busy    = (state != ST_IDLE);
    assign player_sprite = (anim_cnt < ANIM_SPL) ? 4'd3 : 4'd2;

    // Direction priority: right > left > down > up.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        move_dir = DIR_UP;
        if (cmd_buf[3])      move_dir = DIR_RIGHT;
        else if (cmd_buf[2]) move_dir = DIR_LEFT;
        else if (cmd_buf[1]) move_dir = DIR_DOWN;
        else if (cmd_buf[0]) move_dir = DIR_UP;
    end

    // A bare attack press swings in the current facing.
    assign atk_dir = has_dir ? move_dir : player_direction;
    assign sel_dir = (state == ST_ATTACK) ? atk_dir : move_dir;

    // Neighbour tile in sel_dir; bounds are checked before the step, so a
    // rejected target is never applied and coordinates never wrap.
    always_comb begin
        tgt_x  = player_x;
        tgt_y  = player_y;
        tgt_ok = 1'b0;
        case (sel_dir)
            DIR_UP: begin
                tgt_ok = (player_y > Y_LO);
                tgt_y  = player_y - YW'(1);
            end
            DIR_RIGHT: begin
                tgt_ok = (player_x < X_HI);
                tgt_x  = player_x + XW'(1);
            end
            DIR_DOWN: begin
                tgt_ok = (player_y < Y_HI);
                tgt_y  = player_y + YW'(1);
            end
            default: begin
                tgt_ok = (player_x > X_LO);
                tgt_x  = player_x - XW'(1);
            end
        endcase
    end

    // Next-state logic. ATTACK is entered with cnt=0. The trigger that sees
    // cnt=0 in ATTACK places the sword, and the trigger that sees
    // cnt=ATTACK_TICKS removes it, so the sword is shown for ATTACK_TICKS triggers.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        move_now   = 1'b0;
        atk_entry  = 1'b0;
        atk_exit   = 1'b0;
        if (step) begin
            case (state)
                ST_IDLE: begin
                    if (armed && cmd_buf[4]) begin
                        state_next = ST_ATTACK;
                        cnt_next   = '0;
                    end else if (armed && has_dir) begin
                        state_next = ST_MOVE;
                        cnt_next   = '0;
                    end
                end
                ST_MOVE: begin
                    move_now   = 1'b1;
                    state_next = (COOLDOWN_TICKS == 0) ? ST_IDLE : ST_COOLDOWN;
                    cnt_next   = '0;
                end
                ST_ATTACK: begin
                    if (cnt == ATK_LAST) begin
                        atk_exit   = 1'b1;
                        state_next = (COOLDOWN_TICKS == 0) ? ST_IDLE : ST_COOLDOWN;
                        cnt_next   = '0;
                    end else begin
                        atk_entry = (cnt == '0);
                        cnt_next  = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (cnt == COOL_LAST) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            anim_cnt           <= '0;
            cmd_buf            <= '0;
            armed              <= 1'b0;
            player_x           <= X_SPN;
            player_y           <= Y_SPN;
            player_direction   <= DIR_RIGHT;
            player_orientation <= DIR_RIGHT;
            sword_x            <= '0;
            sword_y            <= '0;
            sword_visible      <= 1'b0;
            sword_orientation  <= DIR_RIGHT;
        end else begin
            // The input buffer runs every clock, whether or not freeze is set.
            if (|btn_press)        cmd_buf <= btn_press;
            else if (|btn_release) cmd_buf <= '0;

            if (respawn) begin
                state         <= ST_IDLE;
                cnt           <= '0;
                anim_cnt      <= '0;
                armed         <= 1'b0;
                player_x      <= X_SPN;
                player_y      <= Y_SPN;
                sword_x       <= '0;
                sword_y       <= '0;
                sword_visible <= 1'b0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;

                if (step)
                    anim_cnt <= (anim_cnt == ANIM_LAST) ? '0 : anim_cnt + AW'(1);

                // A fresh press re-arms even on the cycle an action consumes the old one.
                if (|btn_press)                armed <= 1'b1;
                else if (move_now || atk_entry) armed <= 1'b0;

                if (move_now && has_dir) begin
                    player_direction <= move_dir;
                    if (move_dir[0]) player_orientation <= move_dir;
                    if (tgt_ok) begin
                        player_x <= tgt_x;
                        player_y <= tgt_y;
                    end
                end

                if (atk_entry) begin
                    player_direction  <= atk_dir;
                    sword_orientation <= atk_dir;
                    sword_visible     <= tgt_ok;
                    sword_x           <= tgt_ok ? tgt_x : '0;
                    sword_y           <= tgt_ok ? tgt_y : '0;
                end

                if (atk_exit) begin
                    sword_visible <= 1'b0;
                    sword_x       <= '0;
                    sword_y       <= '0;
                end
            end
        end
    end

endmodule
